// File: rtl/prga_enc_if.sv
// prga_enc_if: start handshake plus the three RAM ports driven by prga_enc.
// The master side is the encoder. The slave side is the RAM/host environment.
interface prga_enc_if;
  // Start handshake
  logic       en;
  logic       rdy;
  // S memory (read/write)
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  // Plaintext memory (read only)
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  // Ciphertext memory (write only)
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;

  modport master (
    input  en,
    input  s_rddata,
    input  pt_rddata,
    output rdy,
    output s_addr,
    output s_wrdata,
    output s_wren,
    output pt_addr,
    output ct_addr,
    output ct_wrdata,
    output ct_wren
  );

  modport slave (
    output en,
    output s_rddata,
    output pt_rddata,
    input  rdy,
    input  s_addr,
    input  s_wrdata,
    input  s_wren,
    input  pt_addr,
    input  ct_addr,
    input  ct_wrdata,
    input  ct_wren
  );
endinterface

// File: rtl/prga_enc.sv
// prga_enc: RC4 keystream encryptor.
// Reads a length-prefixed plaintext from pt memory and walks the RC4 PRGA over an
// already-scheduled S memory. Writes the length-prefixed ciphertext ct[k] = pt[k] ^ pad[k].
// Optional feature macro PRGA_ENC_CSUM_EN adds the csum output, the running XOR of
// ct[1..len].
// Every RAM read takes two cycles: the address is presented and the data is sampled one
// cycle later. Every write is a single-cycle wren pulse.
module prga_enc #(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  prga_enc_if.master bus
`ifdef PRGA_ENC_CSUM_EN
  ,
  output logic [7:0] csum
`endif
);

  localparam logic [7:0] MaxLen = 8'(MAX_LEN);

  typedef enum logic [3:0] {
    StIdle,
    StRdLen,
    StWrLen,
    StRdSi,
    StRdSj,
    StWrSi,
    StWrSj,
    StRdPad,
    StRdPt,
    StWrCt
  } state_e;

  state_e     state_q;
  // Read states: 0 = address presented, 1 = data valid this cycle.
  // StWrSj: 0 = gap cycle that keeps the two S writes as separate pulses.
  logic       wait_q;
  logic [7:0] i_q;
  logic [7:0] j_q;
  logic [7:0] k_q;
  logic [7:0] len_q;
  logic [7:0] si_q;
  logic [7:0] sj_q;
  logic [7:0] pad_q;
  logic       rdy_q;
  logic [7:0] s_addr_q;
  logic [7:0] s_wrdata_q;
  logic       s_wren_q;
  logic [7:0] pt_addr_q;
  logic [7:0] ct_addr_q;
  logic [7:0] ct_wrdata_q;
  logic       ct_wren_q;
`ifdef PRGA_ENC_CSUM_EN
  logic [7:0] csum_q;
`endif

  logic [7:0] len_clamp;
  logic [7:0] i_inc;
  logic [7:0] j_next;
  logic [7:0] pad_addr;
  logic [7:0] ct_byte;

  // Index arithmetic, all 8-bit wrap-around
  always_comb begin
    len_clamp = (bus.pt_rddata > MaxLen) ? MaxLen : bus.pt_rddata;
    i_inc     = i_q + 8'd1;
    j_next    = j_q + bus.s_rddata;
    // After the swap s[i] and s[j] are exchanged, so their sum is unchanged.
    pad_addr  = si_q + sj_q;
    ct_byte   = bus.pt_rddata ^ pad_q;
  end

  // Control FSM with registered RAM-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= 1'b0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      pad_q       <= 8'd0;
      rdy_q       <= 1'b1;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= 8'd0;
      ct_addr_q   <= 8'd0;
      ct_wrdata_q <= 8'd0;
      ct_wren_q   <= 1'b0;
`ifdef PRGA_ENC_CSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.en && rdy_q) begin
            rdy_q     <= 1'b0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            k_q       <= 8'd0;
            wait_q    <= 1'b0;
            pt_addr_q <= 8'd0;
`ifdef PRGA_ENC_CSUM_EN
            csum_q    <= 8'd0;
`endif
            state_q   <= StRdLen;
          end
        end

        StRdLen: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q      <= 1'b0;
            len_q       <= len_clamp;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= len_clamp;
            ct_wren_q   <= 1'b1;
            state_q     <= StWrLen;
          end
        end

        StWrLen: begin
          ct_wren_q <= 1'b0;
          if (len_q == 8'd0) begin
            rdy_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            k_q      <= 8'd1;
            i_q      <= i_inc;
            s_addr_q <= i_inc;
            state_q  <= StRdSi;
          end
        end

        StRdSi: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q   <= 1'b0;
            si_q     <= bus.s_rddata;
            j_q      <= j_next;
            s_addr_q <= j_next;
            state_q  <= StRdSj;
          end
        end

        StRdSj: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q     <= 1'b0;
            sj_q       <= bus.s_rddata;
            s_addr_q   <= i_q;
            s_wrdata_q <= bus.s_rddata;
            s_wren_q   <= 1'b1;
            state_q    <= StWrSi;
          end
        end

        StWrSi: begin
          s_wren_q <= 1'b0;
          wait_q   <= 1'b0;
          state_q  <= StWrSj;
        end

        StWrSj: begin
          if (!wait_q) begin
            wait_q     <= 1'b1;
            s_addr_q   <= j_q;
            s_wrdata_q <= si_q;
            s_wren_q   <= 1'b1;
          end else begin
            wait_q   <= 1'b0;
            s_wren_q <= 1'b0;
            s_addr_q <= pad_addr;
            state_q  <= StRdPad;
          end
        end

        StRdPad: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q    <= 1'b0;
            pad_q     <= bus.s_rddata;
            pt_addr_q <= k_q;
            state_q   <= StRdPt;
          end
        end

        StRdPt: begin
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q      <= 1'b0;
            ct_addr_q   <= k_q;
            ct_wrdata_q <= ct_byte;
            ct_wren_q   <= 1'b1;
`ifdef PRGA_ENC_CSUM_EN
            csum_q      <= csum_q ^ ct_byte;
`endif
            state_q     <= StWrCt;
          end
        end

        StWrCt: begin
          ct_wren_q <= 1'b0;
          if (k_q == len_q) begin
            rdy_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            k_q      <= k_q + 8'd1;
            i_q      <= i_inc;
            s_addr_q <= i_inc;
            state_q  <= StRdSi;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive the bus straight from the registers
  always_comb begin
    bus.rdy       = rdy_q;
    bus.s_addr    = s_addr_q;
    bus.s_wrdata  = s_wrdata_q;
    bus.s_wren    = s_wren_q;
    bus.pt_addr   = pt_addr_q;
    bus.ct_addr   = ct_addr_q;
    bus.ct_wrdata = ct_wrdata_q;
    bus.ct_wren   = ct_wren_q;
  end

`ifdef PRGA_ENC_CSUM_EN
  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_prga_enc.sv
// tb_prga_enc: self-checking bench for prga_enc.
// Two DUTs share clock and reset: dut0 with the default MAX_LEN and dut1 with MAX_LEN=4.
// The RAMs and a plain RC4 PRGA reference model live in the bench.
module tb_prga_enc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prga_enc_if bus0 ();
  prga_enc_if bus1 ();

`ifdef PRGA_ENC_CSUM_EN
  logic [7:0] csum0, csum1;
`endif

  prga_enc u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
`ifdef PRGA_ENC_CSUM_EN
    ,
    .csum  (csum0)
`endif
  );

  prga_enc #(.MAX_LEN(4)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef PRGA_ENC_CSUM_EN
    ,
    .csum  (csum1)
`endif
  );

  // Memories, read data registered one cycle after the address
  logic [7:0] s_mem  [2][256];
  logic [7:0] pt_mem [2][256];
  logic [7:0] ct_mem [2][256];
  logic [7:0] s_rd   [2];
  logic [7:0] pt_rd  [2];
  logic [7:0] s_stage  [256];
  logic [7:0] pt_stage [256];
  bit         ld_req, ld_s, ld_p, clr;
  int         ld_d;
  int         ct_cnt [2];
  int         s_cnt  [2];
  int         pt_max [2];
  int         both_cnt, dbl_cnt;
  logic       prev_s [2];

  assign bus0.s_rddata  = s_rd[0];
  assign bus0.pt_rddata = pt_rd[0];
  assign bus1.s_rddata  = s_rd[1];
  assign bus1.pt_rddata = pt_rd[1];

  always @(posedge clk) begin
    if (ld_req) begin
      for (int x = 0; x < 256; x++) begin
        if (ld_s) s_mem[ld_d][x] <= s_stage[x];
        if (ld_p) begin
          pt_mem[ld_d][x] <= pt_stage[x];
          ct_mem[ld_d][x] <= 8'hee;
        end
      end
    end else begin
      if (bus0.s_wren)  s_mem[0][bus0.s_addr]   <= bus0.s_wrdata;
      if (bus0.ct_wren) ct_mem[0][bus0.ct_addr] <= bus0.ct_wrdata;
      if (bus1.s_wren)  s_mem[1][bus1.s_addr]   <= bus1.s_wrdata;
      if (bus1.ct_wren) ct_mem[1][bus1.ct_addr] <= bus1.ct_wrdata;
    end
    s_rd[0]  <= s_mem[0][bus0.s_addr];
    pt_rd[0] <= pt_mem[0][bus0.pt_addr];
    s_rd[1]  <= s_mem[1][bus1.s_addr];
    pt_rd[1] <= pt_mem[1][bus1.pt_addr];
    prev_s[0] <= bus0.s_wren;
    prev_s[1] <= bus1.s_wren;
    if (clr) begin
      ct_cnt[0] <= 0; ct_cnt[1] <= 0; s_cnt[0] <= 0; s_cnt[1] <= 0;
      pt_max[0] <= 0; pt_max[1] <= 0; both_cnt <= 0; dbl_cnt <= 0;
    end else begin
      if (bus0.ct_wren) ct_cnt[0] <= ct_cnt[0] + 1;
      if (bus1.ct_wren) ct_cnt[1] <= ct_cnt[1] + 1;
      if (bus0.s_wren)  s_cnt[0]  <= s_cnt[0] + 1;
      if (bus1.s_wren)  s_cnt[1]  <= s_cnt[1] + 1;
      if (!bus0.rdy && int'(bus0.pt_addr) > pt_max[0]) pt_max[0] <= int'(bus0.pt_addr);
      if (!bus1.rdy && int'(bus1.pt_addr) > pt_max[1]) pt_max[1] <= int'(bus1.pt_addr);
      if ((bus0.s_wren && bus0.ct_wren) || (bus1.s_wren && bus1.ct_wren))
        both_cnt <= both_cnt + 1;
      if ((bus0.s_wren && prev_s[0]) || (bus1.s_wren && prev_s[1])) dbl_cnt <= dbl_cnt + 1;
    end
  end

  // Reference model state
  logic [7:0] ms  [2][256];
  logic [7:0] mpt [2][256];
  logic [7:0] mct [256];
  logic [7:0] mcsum;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input int d, input logic v);
    if (d == 0) bus0.en = v;
    else        bus1.en = v;
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? bus0.rdy : bus1.rdy;
  endfunction

  // Copy the staging arrays into a DUT's memories and into the model
  task automatic load_mem(input int d, input bit do_s, input bit do_p);
    @(negedge clk);
    ld_d = d; ld_s = do_s; ld_p = do_p; ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    for (int x = 0; x < 256; x++) begin
      if (do_s) ms[d][x] = s_stage[x];
      if (do_p) mpt[d][x] = pt_stage[x];
    end
  endtask

  task automatic stage_identity();
    for (int x = 0; x < 256; x++) s_stage[x] = 8'(x);
  endtask

  // Textbook RC4 PRGA over the model S array
  task automatic model_job(input int d, input int max_len, output int len);
    int i, j;
    logic [7:0] t, pad;
    len = (int'(mpt[d][0]) > max_len) ? max_len : int'(mpt[d][0]);
    mct[0] = 8'(len);
    mcsum = 8'h00;
    i = 0; j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(ms[d][i])) % 256;
      t = ms[d][i]; ms[d][i] = ms[d][j]; ms[d][j] = t;
      pad = ms[d][(int'(ms[d][i]) + int'(ms[d][j])) % 256];
      mct[k] = mpt[d][k] ^ pad;
      mcsum = mcsum ^ mct[k];
    end
  endtask

  // Start a job, wait for completion (bounded), return busy cycle count
  task automatic run_job(input int d, input bit hold, output int cyc);
    @(negedge clk);
    clr = 1'b1;
    set_en(d, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    if (!hold) set_en(d, 1'b0);
    cyc = 0;
    while (!get_rdy(d) && cyc < 4000) begin
      cyc++;
      @(negedge clk);
    end
    set_en(d, 1'b0);
    chk("job_done", {31'd0, get_rdy(d)}, 32'd1);
    chk("busy_seen", {31'd0, cyc > 0}, 32'd1);
    @(negedge clk);
    chk("rdy_stays", {31'd0, get_rdy(d)}, 32'd1);
  endtask

  task automatic verify(input int d, input int len, input int cyc, input string tag);
    int bad;
    $display("check %s len=%0d cycles=%0d", tag, len, cyc);
    chk("cycle_bound", {31'd0, cyc <= 6 + 12 * len}, 32'd1);
    chk("ct_writes", ct_cnt[d], len + 1);
    chk("s_writes", s_cnt[d], 2 * len);
    chk("wren_overlap", both_cnt, 0);
    chk("s_wren_pulse", dbl_cnt, 0);
    bad = 0;
    for (int k = 0; k <= len; k++) if (ct_mem[d][k] !== mct[k]) bad++;
    chk("ct_bytes", bad, 0);
    if (len < 255) chk("ct_past_end", ct_mem[d][len+1], 8'hee);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[d][x] !== ms[d][x]) bad++;
    chk("s_state", bad, 0);
`ifdef PRGA_ENC_CSUM_EN
    if (d == 0) chk("csum", csum0, mcsum);
`endif
  endtask

  initial begin
    int len, cyc, plen;
    rst_n = 1'b0;
    bus0.en = 1'b0; bus1.en = 1'b0;
    ld_req = 1'b0; ld_s = 1'b0; ld_p = 1'b0; ld_d = 0; clr = 1'b1;
    for (int x = 0; x < 256; x++) pt_stage[x] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, bus0.rdy}, 32'd1);
    chk("rst_s_wren", {31'd0, bus0.s_wren}, 32'd0);
    chk("rst_ct_wren", {31'd0, bus0.ct_wren}, 32'd0);
    chk("rst_addrs", {bus0.s_addr, bus0.pt_addr, bus0.ct_addr, 8'h00}, 32'd0);
    chk("rst_wrdata", {16'd0, bus0.s_wrdata, bus0.ct_wrdata}, 32'd0);
    rst_n = 1'b1;
    clr = 1'b0;

    // Identity S, one byte
    stage_identity();
    pt_stage[0] = 8'd1; pt_stage[1] = 8'h41;
    load_mem(0, 1'b1, 1'b1);
    model_job(0, 255, len);
    run_job(0, 1'b0, cyc);
    verify(0, len, cyc, "ident_l1");
    chk("ident_l1_ct1", ct_mem[0][1], 8'h43);

    // Identity S, two bytes
    stage_identity();
    pt_stage[0] = 8'd2; pt_stage[1] = 8'h41; pt_stage[2] = 8'h42;
    load_mem(0, 1'b1, 1'b1);
    model_job(0, 255, len);
    run_job(0, 1'b0, cyc);
    verify(0, len, cyc, "ident_l2");
    chk("ident_l2_ct", {8'd0, ct_mem[0][0], ct_mem[0][1], ct_mem[0][2]}, 32'h00024347);
    chk("ident_l2_s23", {16'd0, s_mem[0][2], s_mem[0][3]}, 32'h0302);
`ifdef PRGA_ENC_CSUM_EN
    chk("ident_l2_csum", csum0, 8'h04);
`endif

    // Zero length
    pt_stage[0] = 8'd0;
    load_mem(0, 1'b0, 1'b1);
    model_job(0, 255, len);
    run_job(0, 1'b0, cyc);
    verify(0, len, cyc, "len0");
    chk("len0_rdy_4", {31'd0, cyc <= 4}, 32'd1);
    chk("len0_ct0", ct_mem[0][0], 8'h00);

    // en held high for the whole job: exactly one job
    stage_identity();
    pt_stage[0] = 8'd2; pt_stage[1] = 8'h41; pt_stage[2] = 8'h42;
    load_mem(0, 1'b1, 1'b1);
    model_job(0, 255, len);
    run_job(0, 1'b1, cyc);
    verify(0, len, cyc, "en_held");

    // Reset mid-byte, then a clean rerun
    load_mem(0, 1'b0, 1'b1);
    @(negedge clk);
    bus0.en = 1'b1;
    @(negedge clk);
    bus0.en = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", {31'd0, bus0.rdy}, 32'd1);
    chk("abort_wren", {30'd0, bus0.s_wren, bus0.ct_wren}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stage_identity();
    load_mem(0, 1'b1, 1'b1);
    model_job(0, 255, len);
    run_job(0, 1'b0, cyc);
    verify(0, len, cyc, "after_abort");
    chk("after_abort_ct", {8'd0, ct_mem[0][0], ct_mem[0][1], ct_mem[0][2]}, 32'h00024347);

    // Clamp on the MAX_LEN=4 instance
    stage_identity();
    for (int x = 1; x < 256; x++) pt_stage[x] = 8'($urandom);
    pt_stage[0] = 8'd9;
    load_mem(1, 1'b1, 1'b1);
    model_job(1, 4, len);
    run_job(1, 1'b0, cyc);
    verify(1, len, cyc, "clamp");
    chk("clamp_ct0", ct_mem[1][0], 8'h04);
    chk("clamp_pt_max", pt_max[1], 4);

    // Random S, chained random jobs without restoring S
    for (int x = 0; x < 256; x++) s_stage[x] = 8'($urandom);
    for (int n = 0; n < 6; n++) begin
      for (int x = 1; x < 256; x++) pt_stage[x] = 8'($urandom);
      plen = (n == 5) ? $urandom_range(100, 255) : $urandom_range(0, 20);
      pt_stage[0] = 8'(plen);
      load_mem(0, n == 0, 1'b1);
      model_job(0, 255, len);
      run_job(0, 1'b0, cyc);
      verify(0, len, cyc, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
